// File: rtl/mm_host_bridge_pkg.sv
// ----------------------------------------------------------------------------
// mm_bridge_pkg : shared types and constants for the host bridge slice
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mm_bridge_pkg;

  localparam int CNT_W = 16;

  localparam logic [63:0] TO_PATTERN_DEFAULT = 64'hDEAD_0BAD_DEAD_0BAD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_GAP  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_RESP = 2'd3
  } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/mm_host_bridge_if.sv
// ----------------------------------------------------------------------------
// mm_host_bridge_if : host Avalon-MM slave port plus decoder-side bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mm_host_bridge_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
);

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;

  logic [ADDR_W-1:0] mm_addr;
  logic [DATA_W-1:0] mm_wr_data;
  logic              mm_wr_en;
  logic              mm_rd_en;
  logic [DATA_W-1:0] mm_rd_data;
  logic              mm_rd_data_v;

  // Bridge view: host requests in, decoder strobes out.
  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid,
    output mm_addr, mm_wr_data, mm_wr_en, mm_rd_en,
    input  mm_rd_data, mm_rd_data_v
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid,
    input  mm_addr, mm_wr_data, mm_wr_en, mm_rd_en,
    output mm_rd_data, mm_rd_data_v
  );

endinterface

`default_nettype wire

// File: rtl/mm_host_bridge_sat_cnt16.sv
// ----------------------------------------------------------------------------
// sat_cnt16 : 16-bit increment-enable counter that sticks at all-ones
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_cnt16
  import mm_bridge_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/mm_host_bridge.sv
// ----------------------------------------------------------------------------
// mm_host_bridge : single-outstanding Avalon-MM host to decoder bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mm_host_bridge
  import mm_bridge_pkg::*;
#(
  parameter int                ADDR_W     = 17,
  parameter int                DATA_W     = 64,
  parameter int                TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] TO_PATTERN = DATA_W'(TO_PATTERN_DEFAULT)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mm_host_bridge_if.slave       bus,
  output logic                  rd_timeout,
  output logic      [CNT_W-1:0] timeout_cnt,
  output logic      [CNT_W-1:0] stray_cnt,
  output logic                  req_err
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  bridge_state_e     state_q, state_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              rdv_q, rdv_d;
  logic              waitreq_q, waitreq_d;
  logic              rd_timeout_q, rd_timeout_d;
  logic              req_err_q, req_err_d;
  logic              to_inc;
  logic              stray_inc;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    rd_data_d    = rd_data_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    rdv_d        = 1'b0;
    rd_timeout_d = 1'b0;
    req_err_d    = req_err_q;
    to_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous read and write services the read and drops the write.
        if (bus.avs_read) begin
          addr_d     = bus.avs_address;
          rd_en_d    = 1'b1;
          wait_cnt_d = 16'd1;
          state_d    = ST_RD_WAIT;
          if (bus.avs_write) begin
            req_err_d = 1'b1;
          end
        end else if (bus.avs_write) begin
          addr_d    = bus.avs_address;
          wr_data_d = bus.avs_writedata;
          wr_en_d   = 1'b1;
          state_d   = ST_WR_GAP;
        end
      end

      ST_WR_GAP: begin
        state_d = ST_IDLE;
      end

      ST_RD_WAIT: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (bus.mm_rd_data_v) begin
          rd_data_d = bus.mm_rd_data;
          rdv_d     = 1'b1;
          state_d   = ST_RD_RESP;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          rd_data_d    = TO_PATTERN;
          rdv_d        = 1'b1;
          rd_timeout_d = 1'b1;
          to_inc       = 1'b1;
          state_d      = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered decode of the next state keeps the host stall free of
    // any combinational path from the request inputs.
    waitreq_d = (state_d != ST_IDLE);
  end

  assign stray_inc = bus.mm_rd_data_v && (state_q != ST_RD_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      rd_data_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rdv_q        <= 1'b0;
      waitreq_q    <= 1'b0;
      rd_timeout_q <= 1'b0;
      req_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      rd_data_q    <= rd_data_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      rdv_q        <= rdv_d;
      waitreq_q    <= waitreq_d;
      rd_timeout_q <= rd_timeout_d;
      req_err_q    <= req_err_d;
    end
  end

  sat_cnt16 u_timeout_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (to_inc),
    .count (timeout_cnt)
  );

  sat_cnt16 u_stray_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stray_inc),
    .count (stray_cnt)
  );

  assign bus.avs_waitrequest   = waitreq_q;
  assign bus.avs_readdata      = rd_data_q;
  assign bus.avs_readdatavalid = rdv_q;
  assign bus.mm_addr           = addr_q;
  assign bus.mm_wr_data        = wr_data_q;
  assign bus.mm_wr_en          = wr_en_q;
  assign bus.mm_rd_en          = rd_en_q;
  assign rd_timeout            = rd_timeout_q;
  assign req_err               = req_err_q;

endmodule

`default_nettype wire

// File: doc/mm_host_bridge.md
Name: mm_host_bridge

Overview:
Single-outstanding bridge between the host Avalon-MM slave port and the link-level register address decoder.
- Converts host read/write transfers into one-cycle mm_rd_en/mm_wr_en pulses with registered address and write data.
- Holds the host in waitrequest until read data returns.
- Synthesises an error response on read timeout.
- Keeps timeout and stray-response counters for debug.

Parameters:
ADDR_W, 17, word address width on both sides
DATA_W, 64, data width on both sides
TIMEOUT, 255, max cycles waited for mm_rd_data_v after mm_rd_en (legal range 8..65535)
TO_PATTERN, 64'hDEAD_0BAD_DEAD_0BAD, readdata returned on timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W  host word address
avs_read  in  1  host read request
avs_write  in  1  host write request
avs_writedata  in  DATA_W  host write data
avs_waitrequest  out  1  stall host; transfer accepted when request & !avs_waitrequest
avs_readdata  out  DATA_W  read data
avs_readdatavalid  out  1  one-cycle read data strobe
mm_addr  out  ADDR_W  address to decoder
mm_wr_data  out  DATA_W  write data to decoder
mm_wr_en  out  1  one-cycle write pulse
mm_rd_en  out  1  one-cycle read pulse
mm_rd_data  in  DATA_W  read data from decoder
mm_rd_data_v  in  1  read data valid from decoder
rd_timeout  out  1  one-cycle pulse when a read times out
timeout_cnt  out  16  saturating count of timeouts
stray_cnt  out  16  saturating count of mm_rd_data_v seen outside RD_WAIT
req_err  out  1  sticky; set when avs_read & avs_write are accepted together

Behaviour:
- Reset: clk and rst_n as stated above. All outputs 0, except avs_waitrequest = 0. FSM = IDLE, counters = 0, req_err = 0.
- FSM states: IDLE, WR_GAP, RD_WAIT, RD_RESP.
- avs_waitrequest is 0 only in IDLE. It is a registered state decode, with no combinational path from avs_* inputs.
- IDLE, avs_write accepted at cycle N:
  - At N+1: mm_wr_en = 1; mm_addr and mm_wr_data hold the captured values.
  - FSM → WR_GAP for one cycle, then IDLE.
  - A back-to-back write therefore issues every 2 cycles.
- IDLE, avs_read accepted at cycle N:
  - At N+1: mm_rd_en = 1 with mm_addr; FSM → RD_WAIT; wait counter cleared to 1.
- IDLE, avs_read & avs_write both high: the read is serviced, the write is dropped, req_err is set. req_err clears only on reset.
- RD_WAIT:
  - The wait counter increments each cycle.
  - mm_rd_data_v = 1: capture mm_rd_data; FSM → RD_RESP.
  - Counter reaches TIMEOUT with no valid: load TO_PATTERN, pulse rd_timeout, increment timeout_cnt (saturating at 16'hFFFF); FSM → RD_RESP.
  - If valid and timeout occur in the same cycle, valid wins: no timeout is counted.
- RD_RESP (one cycle): avs_readdatavalid = 1 with avs_readdata; FSM → IDLE.
  - Latency: a downstream valid at cycle M gives avs_readdatavalid at M+1.
  - The host is released (waitrequest 0) at M+2.
- avs_readdata holds its last value between strobes.
- mm_rd_data_v in any state other than RD_WAIT is ignored for data and increments stray_cnt (saturating).
  - Late responses after a timeout are therefore absorbed.
  - TIMEOUT must exceed the worst downstream latency; the decoder latency is 3 cycles from mm_rd_en.
- mm_wr_en and mm_rd_en are never high together and never high for 2 consecutive cycles.
- mm_addr and mm_wr_data hold their values until the next accepted transfer.
- Reset mid-read: the FSM returns to IDLE asynchronously and no readdatavalid is issued. The host is expected to be reset with the bridge.

Decomposition:
- Shared package mm_bridge_pkg holds:
  - state enum typedef (IDLE, WR_GAP, RD_WAIT, RD_RESP)
  - TO_PATTERN default constant
  - the 16-bit saturating-counter width constant
- Sub-module sat_cnt16 (increment-enable, saturate at 16'hFFFF, async reset) is instantiated twice, for timeout_cnt and stray_cnt.

Test Plan:
- Write 0x0_4010 data 0x1122334455667788 at cycle N → mm_wr_en=1 at N+1 with mm_addr=0x04010 and matching data; waitrequest=1 at N+1, 0 at N+2.
- Read 0x0_8000, downstream valid 3 cycles after mm_rd_en with data 0xCAFE → avs_readdatavalid one cycle later with 0xCAFE; exactly one mm_rd_en pulse.
- Read with no downstream response, TIMEOUT=16 → readdatavalid with 0xDEAD0BADDEAD0BAD at wait count 16, plus one cycle; rd_timeout pulse; timeout_cnt=1.
- Late valid 5 cycles after a timeout → no readdatavalid; stray_cnt=1; next read returns correct data.
- avs_read & avs_write together at address 0x10 → single mm_rd_en, no mm_wr_en, req_err=1 until reset.
- Assert rst_n low while in RD_WAIT, release, then issue a write → no readdatavalid, all counters 0, write issued normally.
